// File: rtl/controle_pkg.sv
// Shared constants and types for the multi-pad Sega controller scanner.
// Optional feature macro: CONTROLE_SIX_BUTTON_EN (8-phase scan with X/Y/Z/Mode decode).
package controle_pkg;

`ifdef CONTROLE_SIX_BUTTON_EN
  localparam int          NPHASE    = 8;
  localparam logic [11:0] LIVE_MASK = 12'hFFF;
`else
  localparam int          NPHASE    = 4;
  localparam logic [11:0] LIVE_MASK = 12'h0FF;
`endif

  // Phases in which a decode happens; the other phases only settle the pad.
  localparam logic [2:0] PH_DPAD = 3'd0;
  localparam logic [2:0] PH_TYPE = 3'd1;
  localparam logic [2:0] PH_ID   = 3'd5;
  localparam logic [2:0] PH_XYZ  = 3'd6;

  // Bit positions inside one pad's 6-bit pin group: {9,6,4,3,2,1}.
  localparam int PIN1 = 0;
  localparam int PIN2 = 1;
  localparam int PIN3 = 2;
  localparam int PIN4 = 3;
  localparam int PIN6 = 4;
  localparam int PIN9 = 5;

  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_A     = 4;
  localparam int BTN_B     = 5;
  localparam int BTN_C     = 6;
  localparam int BTN_START = 7;
  localparam int BTN_X     = 8;
  localparam int BTN_Y     = 9;
  localparam int BTN_Z     = 10;
  localparam int BTN_MODE  = 11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_COMMIT = 2'd3
  } state_e;

endpackage

// File: rtl/controle_multipad_if.sv
// Pad-side pins and button-word outputs of the multi-pad scanner.
// The scanner uses the slave modport; whoever drives v_sync and the pad pins uses master.
interface controle_multipad_if #(
  parameter int NUM_PADS = 2
);

  logic                    v_sync;
  logic [6*NUM_PADS-1:0]   Pinos;
  logic [NUM_PADS-1:0]     Select;
  logic [12*NUM_PADS-1:0]  Saidas;
  logic [12*NUM_PADS-1:0]  Pressed;
  logic [NUM_PADS-1:0]     Presente;
  logic [NUM_PADS-1:0]     SeisBotoes;
  logic                    Valid;

  modport master (
    output v_sync, Pinos,
    input  Select, Saidas, Pressed, Presente, SeisBotoes, Valid
  );

  modport slave (
    input  v_sync, Pinos,
    output Select, Saidas, Pressed, Presente, SeisBotoes, Valid
  );

endinterface

// File: rtl/controle_debounce.sv
// Per-pad frame debouncer: a raw word must repeat DEBOUNCE_FRAMES scans in a row
// before it reaches the published button word; rising bits produce a press pulse.
module controle_debounce #(
  parameter int DEBOUNCE_FRAMES = 2
) (
  input  logic        Clock50,
  input  logic        Reset,
  input  logic        i_commit,
  input  logic [11:0] i_raw,
  output logic [11:0] o_saidas,
  output logic [11:0] o_pressed
);

  localparam int                 CNT_W   = (DEBOUNCE_FRAMES > 1) ? $clog2(DEBOUNCE_FRAMES) : 1;
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(DEBOUNCE_FRAMES - 1);

  logic [11:0]      r_raw;
  logic [CNT_W-1:0] r_cnt;
  logic [11:0]      r_saidas;
  logic [11:0]      r_pressed;
  logic [CNT_W-1:0] w_cnt_next;

  always_comb begin
    // NOTE: default assigned first so no path leaves the signal unassigned (no latch).
    w_cnt_next = '0;
    if (i_raw == r_raw) begin
      w_cnt_next = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
    end
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clock50 or negedge Reset) begin
    if (!Reset) begin
      r_raw     <= '0;
      r_cnt     <= '0;
      r_saidas  <= '0;
      r_pressed <= '0;
    end else begin
      r_pressed <= '0;
      if (i_commit) begin
        r_raw <= i_raw;
        r_cnt <= w_cnt_next;
        if (w_cnt_next == CNT_MAX) begin
          r_saidas  <= i_raw;
          r_pressed <= i_raw & ~r_saidas;
        end
      end
    end
  end

  assign o_saidas  = r_saidas;
  assign o_pressed = r_pressed;

endmodule

// File: rtl/controle_multipad.sv
// Multi-pad Sega gamepad scanner: one timed Select sequence per frame, phase decode per pad,
// per-pad debounce. Optional macro CONTROLE_SIX_BUTTON_EN enables the 6-button phases.
module controle_multipad
  import controle_pkg::*;
#(
  parameter int NUM_PADS        = 2,
  parameter int SETTLE_CYCLES   = 500,
  parameter int DEBOUNCE_FRAMES = 2
) (
  input  logic               Clock50,
  input  logic               Reset,
  controle_multipad_if.slave bus
);

  localparam int               SET_W       = $clog2(SETTLE_CYCLES);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [2:0]       PHASE_LAST  = 3'(NPHASE - 1);

  // [0],[1] synchroniser stages, [2] previous synchronised value for edge detection.
  logic [2:0]               r_vs_sync;
  logic                     w_vs_fall;
  logic [6*NUM_PADS-1:0]    r_pin_s1;
  logic [6*NUM_PADS-1:0]    r_pin_s2;
  logic [6*NUM_PADS-1:0]    w_pin_act;

  state_e                   r_state;
  state_e                   w_state_next;
  logic [2:0]               r_phase;
  logic [2:0]               w_phase_next;
  logic [SET_W-1:0]         r_settle;
  logic [SET_W-1:0]         w_settle_next;
  logic                     r_select;
  logic                     w_select_next;
  logic                     w_sample;
  logic                     w_commit;

  logic [NUM_PADS-1:0][11:0] r_acc;
  logic [NUM_PADS-1:0]       r_present;
`ifdef CONTROLE_SIX_BUTTON_EN
  logic [NUM_PADS-1:0]       r_six;
`endif
  logic [NUM_PADS-1:0][11:0] w_raw;
  logic [NUM_PADS-1:0][11:0] w_saidas;
  logic [NUM_PADS-1:0][11:0] w_pressed;

  logic [NUM_PADS-1:0]       r_presente;
  logic [NUM_PADS-1:0]       r_seis;
  logic                      r_valid;

  always_ff @(posedge Clock50 or negedge Reset) begin
    if (!Reset) begin
      r_vs_sync <= '0;
      r_pin_s1  <= '1;
      r_pin_s2  <= '1;
    end else begin
      r_vs_sync <= {r_vs_sync[1:0], bus.v_sync};
      r_pin_s1  <= bus.Pinos;
      r_pin_s2  <= r_pin_s1;
    end
  end

  assign w_vs_fall = r_vs_sync[2] & ~r_vs_sync[1];
  assign w_pin_act = ~r_pin_s2;

  always_ff @(posedge Clock50 or negedge Reset) begin
    if (!Reset) begin
      r_state  <= ST_IDLE;
      r_phase  <= '0;
      r_settle <= '0;
      r_select <= 1'b1;
    end else begin
      r_state  <= w_state_next;
      r_phase  <= w_phase_next;
      r_settle <= w_settle_next;
      r_select <= w_select_next;
    end
  end

  // Select is registered from its next value so the pad sees a glitch-free line.
  always_comb begin
    w_state_next  = r_state;
    w_phase_next  = r_phase;
    w_settle_next = r_settle;
    w_select_next = r_select;
    w_sample      = 1'b0;
    w_commit      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_select_next = 1'b1;
        if (w_vs_fall) begin
          w_state_next  = ST_SETTLE;
          w_phase_next  = '0;
          w_settle_next = '0;
        end
      end
      ST_SETTLE: begin
        if (r_settle == SETTLE_LAST) begin
          w_state_next = ST_SAMPLE;
        end else begin
          w_settle_next = r_settle + 1'b1;
        end
      end
      ST_SAMPLE: begin
        w_sample = 1'b1;
        if (r_phase == PHASE_LAST) begin
          w_state_next  = ST_COMMIT;
          w_commit      = 1'b1;
          w_select_next = 1'b1;
        end else begin
          w_state_next  = ST_SETTLE;
          w_phase_next  = r_phase + 1'b1;
          w_settle_next = '0;
          w_select_next = ~r_select;
        end
      end
      ST_COMMIT: w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock50 or negedge Reset) begin
    if (!Reset) begin
      r_acc     <= '0;
      r_present <= '0;
`ifdef CONTROLE_SIX_BUTTON_EN
      r_six     <= '0;
`endif
    end else if (w_sample) begin
      for (int p = 0; p < NUM_PADS; p++) begin
        case (r_phase)
          PH_DPAD: begin
            r_acc[p][BTN_UP]    <= w_pin_act[6*p + PIN1];
            r_acc[p][BTN_DOWN]  <= w_pin_act[6*p + PIN2];
            r_acc[p][BTN_LEFT]  <= w_pin_act[6*p + PIN3];
            r_acc[p][BTN_RIGHT] <= w_pin_act[6*p + PIN4];
            r_acc[p][BTN_B]     <= w_pin_act[6*p + PIN6];
            r_acc[p][BTN_C]     <= w_pin_act[6*p + PIN9];
          end
          PH_TYPE: begin
            r_acc[p][BTN_A]     <= w_pin_act[6*p + PIN6];
            r_acc[p][BTN_START] <= w_pin_act[6*p + PIN9];
            r_present[p]        <= ~r_pin_s2[6*p + PIN3] & ~r_pin_s2[6*p + PIN4];
          end
`ifdef CONTROLE_SIX_BUTTON_EN
          PH_ID: begin
            r_six[p] <= (r_pin_s2[6*p +: 4] == 4'b0000);
          end
          PH_XYZ: begin
            r_acc[p][BTN_Z]    <= w_pin_act[6*p + PIN1];
            r_acc[p][BTN_Y]    <= w_pin_act[6*p + PIN2];
            r_acc[p][BTN_X]    <= w_pin_act[6*p + PIN3];
            r_acc[p][BTN_MODE] <= w_pin_act[6*p + PIN4];
          end
`endif
          default: ;
        endcase
      end
    end
  end

  // An absent pad reads as nothing pressed; X/Y/Z/Mode only count on a 6-button pad.
  always_comb begin
    w_raw = '0;
    for (int p = 0; p < NUM_PADS; p++) begin
      if (r_present[p]) begin
`ifdef CONTROLE_SIX_BUTTON_EN
        w_raw[p] = r_acc[p] & (r_six[p] ? LIVE_MASK : 12'h0FF);
`else
        w_raw[p] = r_acc[p] & LIVE_MASK;
`endif
      end
    end
  end

  for (genvar gp = 0; gp < NUM_PADS; gp++) begin : g_pad
    controle_debounce #(
      .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
    ) u_debounce (
      .Clock50   (Clock50),
      .Reset     (Reset),
      .i_commit  (w_commit),
      .i_raw     (w_raw[gp]),
      .o_saidas  (w_saidas[gp]),
      .o_pressed (w_pressed[gp])
    );
  end

  always_ff @(posedge Clock50 or negedge Reset) begin
    if (!Reset) begin
      r_presente <= '0;
      r_seis     <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_valid <= w_commit;
      if (w_commit) begin
        r_presente <= r_present;
`ifdef CONTROLE_SIX_BUTTON_EN
        r_seis     <= r_six & r_present;
`else
        r_seis     <= '0;
`endif
      end
    end
  end

  assign bus.Select     = {NUM_PADS{r_select}};
  assign bus.Saidas     = w_saidas;
  assign bus.Pressed    = w_pressed;
  assign bus.Presente   = r_presente;
  assign bus.SeisBotoes = r_seis;
  assign bus.Valid      = r_valid;

endmodule

// File: tb/tb_controle_multipad.sv
// Scoreboard bench for controle_multipad: behavioural Sega pads on the pins, a reference
// debounce model pushes expected words per frame, popped and compared on each Valid.
module tb_controle_multipad;

  localparam int NUM_PADS = 2;
  localparam int SETTLE   = 4;
  localparam int DEB      = 2;
`ifdef CONTROLE_SIX_BUTTON_EN
  localparam int N_PH   = 8;
  localparam bit SIX_EN = 1'b1;
`else
  localparam int N_PH   = 4;
  localparam bit SIX_EN = 1'b0;
`endif
  // v_sync is driven just after an edge: two sync flops plus the edge flop before SETTLE.
  localparam int LATENCY     = 3 + N_PH * (SETTLE + 1);
  localparam int PAD_TIMEOUT = 12;

  typedef enum {PAD_NONE, PAD_3B, PAD_6B} pad_kind_e;

  typedef struct {
    logic [23:0] saidas;
    logic [23:0] pressed;
    logic [1:0]  presente;
    logic [1:0]  seis;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  controle_multipad_if #(.NUM_PADS(NUM_PADS)) bus ();

  controle_multipad #(
    .NUM_PADS        (NUM_PADS),
    .SETTLE_CYCLES   (SETTLE),
    .DEBOUNCE_FRAMES (DEB)
  ) dut (
    .Clock50 (clk),
    .Reset   (rst_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural pads: each counts Select toggles and forgets after a quiet period.
  pad_kind_e            pad_kind [NUM_PADS] = '{default: PAD_NONE};
  logic [11:0]          pad_btn  [NUM_PADS] = '{default: 12'h000};
  int                   pad_ph   [NUM_PADS] = '{default: 0};
  int                   pad_idle [NUM_PADS] = '{default: 0};
  logic [NUM_PADS-1:0]  sel_q = '1;

  always @(posedge clk) begin
    for (int p = 0; p < NUM_PADS; p++) begin
      sel_q[p] <= bus.Select[p];
      if (bus.Select[p] != sel_q[p]) begin
        pad_ph[p]   <= pad_ph[p] + 1;
        pad_idle[p] <= 0;
      end else if (pad_idle[p] >= PAD_TIMEOUT) begin
        pad_ph[p] <= 0;
      end else begin
        pad_idle[p] <= pad_idle[p] + 1;
      end
    end
  end

  // Pin group order {9,6,4,3,2,1}, active-low.
  function automatic logic [5:0] pad_pins(input pad_kind_e k, input logic [11:0] b,
                                          input logic sel, input int ph);
    if (k == PAD_NONE) return 6'h3F;
    if (sel) begin
      if (k == PAD_6B && ph == 6) return ~{b[6], b[5], b[11], b[8], b[9], b[10]};
      return ~{b[6], b[5], b[3], b[2], b[1], b[0]};
    end
    if (k == PAD_6B && ph == 5) return {~b[7], ~b[4], 4'b0000};
    return {~b[7], ~b[4], 2'b00, ~b[1], ~b[0]};
  endfunction

  always_comb begin
    bus.Pinos = '1;
    for (int p = 0; p < NUM_PADS; p++) begin
      bus.Pinos[6*p +: 6] = pad_pins(pad_kind[p], pad_btn[p], bus.Select[p], pad_ph[p]);
    end
  end

  // Reference model of the frame debounce.
  logic [11:0] m_prev [NUM_PADS] = '{default: 12'h000};
  logic [11:0] m_out  [NUM_PADS] = '{default: 12'h000};
  int          m_cnt  [NUM_PADS] = '{default: 0};
  exp_t        sb_q[$];

  task automatic model_reset();
    for (int p = 0; p < NUM_PADS; p++) begin
      m_prev[p] = '0;
      m_out[p]  = '0;
      m_cnt[p]  = 0;
    end
    sb_q.delete();
  endtask

  task automatic push_expected();
    exp_t        e;
    logic [11:0] raw;
    bit          present;
    bit          six;
    e = '{default: '0};
    for (int p = 0; p < NUM_PADS; p++) begin
      present = (pad_kind[p] != PAD_NONE);
      six     = SIX_EN && (pad_kind[p] == PAD_6B);
      raw     = present ? (pad_btn[p] & (six ? 12'hFFF : 12'h0FF)) : 12'h000;
      if (raw == m_prev[p]) begin
        if (m_cnt[p] < DEB - 1) m_cnt[p]++;
      end else begin
        m_cnt[p]  = 0;
        m_prev[p] = raw;
      end
      if (m_cnt[p] == DEB - 1) begin
        e.pressed[12*p +: 12] = raw & ~m_out[p];
        m_out[p] = raw;
      end
      e.saidas[12*p +: 12] = m_out[p];
      e.presente[p]        = present;
      e.seis[p]            = six;
    end
    sb_q.push_back(e);
  endtask

  logic prev_valid = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_valid <= 1'b0;
    end else begin
      if (prev_valid) begin
        check("valid_one_cycle", 32'(bus.Valid), 32'd0);
        check("pressed_one_cycle", 32'(bus.Pressed), 32'd0);
      end
      if (bus.Valid) begin
        check("valid_expected", 32'(sb_q.size() > 0), 32'd1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          check("saidas", 32'(bus.Saidas), 32'(e.saidas));
          check("pressed", 32'(bus.Pressed), 32'(e.pressed));
          check("presente", 32'(bus.Presente), 32'(e.presente));
          check("seis_botoes", 32'(bus.SeisBotoes), 32'(e.seis));
          check("select_after_scan", 32'(bus.Select), 32'(2'b11));
        end
      end
      prev_valid <= bus.Valid;
    end
  end

  task automatic run_scan(input bit extra_vs);
    int lat;
    lat = 0;
    push_expected();
    @(posedge clk);
    #1 bus.v_sync = 1'b0;
    for (int c = 1; c <= LATENCY + 50; c++) begin
      @(posedge clk);
      #1;
      if (c == 4) bus.v_sync = 1'b1;
      if (extra_vs && c == 13) bus.v_sync = 1'b0;
      if (extra_vs && c == 16) bus.v_sync = 1'b1;
      if (bus.Valid) begin
        lat = c;
        break;
      end
    end
    check("valid_latency", 32'(lat), 32'(LATENCY));
    if (lat == 0) begin
      sb_q.delete();
      bus.v_sync = 1'b1;
    end
    repeat (20) @(posedge clk);
  endtask

  task automatic reset_mid_scan();
    @(posedge clk);
    #1 bus.v_sync = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (c == 4) bus.v_sync = 1'b1;
    end
    check("select_phase3", 32'(bus.Select), 32'(2'b00));
    check("saidas_before_reset", 32'(bus.Saidas), 32'({m_out[1], m_out[0]}));
    rst_n = 1'b0;
    #1;
    check("rst_mid_select", 32'(bus.Select), 32'(2'b11));
    check("rst_mid_saidas", 32'(bus.Saidas), 32'd0);
    check("rst_mid_presente", 32'(bus.Presente), 32'd0);
    check("rst_mid_seis", 32'(bus.SeisBotoes), 32'd0);
    check("rst_mid_valid", 32'(bus.Valid), 32'd0);
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [11:0] b0;
    bus.v_sync = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_select", 32'(bus.Select), 32'(2'b11));
    check("rst_saidas", 32'(bus.Saidas), 32'd0);
    check("rst_pressed", 32'(bus.Pressed), 32'd0);
    check("rst_presente", 32'(bus.Presente), 32'd0);
    check("rst_seis", 32'(bus.SeisBotoes), 32'd0);
    check("rst_valid", 32'(bus.Valid), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);

    // 3-button pad 0 holding A: nothing on the first frame, A and its press on the second.
    pad_kind[0] = PAD_3B;
    pad_btn[0]  = 12'h010;
    run_scan(1'b0);
    run_scan(1'b0);

    // 6-button pad 1 holding X and Start.
    pad_kind[1] = PAD_6B;
    pad_btn[1]  = 12'h180;
    run_scan(1'b0);
    run_scan(1'b0);

    // Pad 0 unplugged while its word is nonzero.
    pad_kind[0] = PAD_NONE;
    run_scan(1'b0);
    run_scan(1'b0);

    // Up bouncing every frame never reaches the output.
    pad_kind[0] = PAD_3B;
    for (int i = 0; i < 6; i++) begin
      pad_btn[0] = (i % 2 == 0) ? 12'h001 : 12'h000;
      run_scan(1'b0);
    end

    // Extra v_sync fall mid-scan is ignored; the next frame scans normally.
    pad_btn[0] = 12'h008;
    run_scan(1'b1);
    run_scan(1'b0);

    // Reset during phase 3, then scanning restarts cleanly.
    pad_btn[0] = 12'h020;
    run_scan(1'b0);
    run_scan(1'b0);
    reset_mid_scan();
    run_scan(1'b0);
    run_scan(1'b0);

    // A few random held patterns, each held for two frames.
    for (int i = 0; i < 3; i++) begin
      b0 = 12'($urandom_range(0, 255));
      if (b0[0] && b0[1]) b0[1] = 1'b0;
      pad_btn[0] = b0;
      pad_btn[1] = 12'($urandom_range(0, 4095));
      run_scan(1'b0);
      run_scan(1'b0);
    end

    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/controle_multipad.md
# controle_multipad

Parametrised Sega-style gamepad scanner that replaces the single-pad `Controle` reader in the robot maze top level. It drives the Select line for up to four pads, samples their six data pins through a timed multi-phase scan started once per video frame, and decodes 3-button or 6-button pads. It debounces across frames and publishes active-high button words plus press pulses to `Controlador`.

## Interface
Parameters:
- `NUM_PADS`, 2: number of pads scanned; legal range 1..4.
- `SETTLE_CYCLES`, 500: `Clock50` cycles the pins settle after each Select change (10 µs); must be ≥ 3.
- `DEBOUNCE_FRAMES`, 2: consecutive identical scans required before `Saidas` updates; must be ≥ 1.

Ports:
- `Clock50`, in, 1: single clock, 50 MHz.
- `Reset`, in, 1: asynchronous, active-low reset.
- `v_sync`, in, 1: VGA vertical sync from the 25 MHz domain; a falling edge starts a scan.
- `Pinos`, in, 6*NUM_PADS: per pad p, bits [6p+5:6p] = pins {9,6,4,3,2,1}; active-low.
- `Select`, out, NUM_PADS: per-pad Select drive; all bits carry the same value.
- `Saidas`, out, 12*NUM_PADS: debounced, active-high buttons. Per-pad bit order is [0]Up, [1]Down, [2]Left, [3]Right, [4]A, [5]B, [6]C, [7]Start, [8]X, [9]Y, [10]Z, [11]Mode.
- `Pressed`, out, 12*NUM_PADS: one-cycle pulse for each bit of `Saidas` that goes 0→1.
- `Presente`, out, NUM_PADS: pad detected in the last scan.
- `SeisBotoes`, out, NUM_PADS: pad identified as 6-button in the last scan.
- `Valid`, out, 1: one-cycle pulse when a scan result is committed.

## Operation
- Synchronisation:
  - `v_sync` passes through 2 flops, then falling-edge detection.
  - `Pinos` passes through 2 flops.
- States: IDLE, SETTLE, SAMPLE, COMMIT.
  - IDLE → SETTLE on a synchronised `v_sync` fall; phase counter is set to 0.
  - SETTLE holds for SETTLE_CYCLES cycles, then → SAMPLE.
  - SAMPLE lasts one cycle. It goes → SETTLE with phase+1 and toggles Select, or → COMMIT after the last phase.
  - COMMIT lasts one cycle and returns → IDLE.
- Select follows the phase: even phases high, odd phases low. In IDLE, Select is high.
- Phase decode, per pad, with pins inverted to active-high:
  - Phase 0 (high): pins 1,2,3,4,6,9 → Up, Down, Left, Right, B, C.
  - Phase 1 (low): pin 6 → A, pin 9 → Start. Raw pins 3 and 4 both low → present.
  - Phase 5 (low): raw pins 1–4 all low → six-button.
  - Phase 6 (high): pins 1,2,3,4 → Z, Y, X, Mode.
- Phase count is 8 with `SIX_BUTTON_EN`, 4 without.
- A pad that is not present commits an all-zero raw word.
- Bits X, Y, Z and Mode are forced to 0 unless the pad is six-button.
- Debounce, per pad, in COMMIT:
  - If raw equals the previous raw, the stable count increments, saturating at DEBOUNCE_FRAMES-1. Otherwise the count clears and raw is stored.
  - When count = DEBOUNCE_FRAMES-1, `Saidas` ← raw.
- `Pressed` = new `Saidas` & ~old `Saidas`, asserted in the COMMIT cycle only.
- `Presente` and `SeisBotoes` update every COMMIT; they are not debounced.

## Timing
- Reset values: `Select` all 1; `Saidas`, `Pressed`, `Presente`, `SeisBotoes`, `Valid` all 0. State is IDLE and all counters are 0.
- Scan latency: `Valid` rises exactly NPHASE*(SETTLE_CYCLES+1) cycles after the IDLE→SETTLE cycle, where NPHASE is 8 or 4.
- `Saidas`, `Pressed` and `Presente` are valid in the same cycle as `Valid`. `Saidas` holds its value until the next COMMIT.
- A `v_sync` fall while not in IDLE is ignored; the scan is not restarted.
- A `v_sync` fall in the COMMIT cycle is also ignored.
- `Reset` asserted mid-scan returns all outputs and state to reset values immediately, and Select goes high.
- With DEBOUNCE_FRAMES = 1, a change reaches `Saidas` on the first scan in which it is seen.

## Configuration
- `CONTROLE_SIX_BUTTON_EN` defined: 8-phase scan, phase 5/6 decode, bits [11:8] live.
- Not defined: 4-phase scan; `SeisBotoes` and bits [11:8] of every pad are tied to 0.

## Structure
- Package `controle_pkg` holds:
  - Button index constants (BTN_UP … BTN_MODE).
  - State enum.
  - `NPHASE` derived from the macro.
  - Phase constants PH_TYPE = 1, PH_ID = 5, PH_XYZ = 6.
- Sub-module `controle_debounce`: one instance per pad. It contains the raw register, stable counter, `Saidas` register and `Pressed` edge logic, clocked by `Clock50` and enabled by COMMIT.
- The scan FSM and phase decode stay in the top module.

## Test plan
- Reset mid-scan: assert `Reset` during phase 3 → `Select` = 1 immediately; all outputs 0; the next `v_sync` fall starts from phase 0.
- 3-button pad 0, A held, SETTLE_CYCLES = 4, DEBOUNCE_FRAMES = 2, macro on:
  - `Valid` arrives 40 cycles after scan start.
  - First frame: `Saidas[11:0]` = 0.
  - Second frame: `Saidas[11:0]` = 12'h010 with `Pressed[4]` = 1 for one cycle.
- 6-button pad 1, X+Start held → `SeisBotoes[1]` = 1 and `Saidas[23:12]` = 12'h180 after 2 frames.
- Pad 0 disconnected (pins pulled high) → `Presente[0]` = 0; `Saidas[11:0]` goes to 0 after 2 frames even if it was nonzero before.
- Bounce: Up toggles on alternate frames for 6 frames → `Saidas[0]` never changes and `Pressed[0]` never pulses.
- Extra `v_sync` fall during phase 2 → no restart; exactly one `Valid` pulse; the following frame scans normally. Repeat with the macro off → 4 phases and `Valid` after 20 cycles.
